// File: rtl/ft245_fifo_responder.sv
// ---------------------------------------------------------------------------
// ft245_fifo_responder
//
// Device-side model of an FTDI FT245 asynchronous FIFO. It answers the
// RXF_n/RD_n/TXE_n/WR_n pin protocol that the FPGA-side adapters drive.
// Host bytes arrive on an Avalon-ST sink and are served through RXF_n/RD_n.
// Bytes written by the FPGA with WR_n are emitted on an Avalon-ST source.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   oFIFO_RXF_n       low = byte available for the FPGA to read
//   iFIFO_RD_n        read strobe from the FPGA
//   oFIFO_DATA        read data to the FPGA (latched on the RD_n falling edge)
//   oFIFO_TXE_n       low = space available for the FPGA to write
//   iFIFO_WR_n        write strobe from the FPGA
//   iFIFO_DATA        write data from the FPGA
//   iHOST_VALID/oHOST_READY/iHOST_DATA   host-to-FPGA sink (readyLatency 0)
//   oHOST_VALID/iHOST_READY/oHOST_DATA   FPGA-to-host source
//   oRX_LEVEL/oTX_LEVEL                  buffer occupancies
//   oRD_UNDERRUN/oWR_OVERRUN             sticky protocol-violation flags
// ---------------------------------------------------------------------------
module ft245_fifo_responder #(
   parameter int DEPTH_LOG2   = 4,
   parameter int RXF_RECOVERY = 4,
   parameter int TXE_RECOVERY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  oFIFO_RXF_n,
   input  logic                  iFIFO_RD_n,
   output logic [7:0]            oFIFO_DATA,
   output logic                  oFIFO_TXE_n,
   input  logic                  iFIFO_WR_n,
   input  logic [7:0]            iFIFO_DATA,
   input  logic                  iHOST_VALID,
   output logic                  oHOST_READY,
   input  logic [7:0]            iHOST_DATA,
   output logic                  oHOST_VALID,
   input  logic                  iHOST_READY,
   output logic [7:0]            oHOST_DATA,
   output logic [DEPTH_LOG2:0]   oRX_LEVEL,
   output logic [DEPTH_LOG2:0]   oTX_LEVEL,
   output logic                  oRD_UNDERRUN,
   output logic                  oWR_OVERRUN
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int RXW   = (RXF_RECOVERY < 1) ? 1 : $clog2(RXF_RECOVERY + 1);
   localparam int TXW   = (TXE_RECOVERY < 1) ? 1 : $clog2(TXE_RECOVERY + 1);

   localparam logic [LW-1:0]  FULL_LVL    = LW'(DEPTH);
   localparam logic [LW-1:0]  ZERO_LVL    = LW'(0);
   localparam logic [LW-1:0]  ONE_LVL     = LW'(1);
   localparam logic [RXW-1:0] RX_REC_LOAD = RXW'(RXF_RECOVERY);
   localparam logic [RXW-1:0] RX_REC_ONE  = RXW'(1);
   localparam logic [RXW-1:0] RX_REC_ZERO = RXW'(0);
   localparam logic [TXW-1:0] TX_REC_LOAD = TXW'(TXE_RECOVERY);
   localparam logic [TXW-1:0] TX_REC_ONE  = TXW'(1);
   localparam logic [TXW-1:0] TX_REC_ZERO = TXW'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      R_IDLE    = 2'd0,
      R_ACTIVE  = 2'd1,
      R_RECOVER = 2'd2
   } rd_state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   rd_state_t                r_rd_state;
   logic                     r_rd_prev;
   logic                     r_wr_prev;
   logic                     r_edge_mask;   // first cycle after reset release
   logic [RXW-1:0]           r_rx_rec;
   logic [TXW-1:0]           r_tx_rec;
   logic [7:0]               r_rx_mem [DEPTH];
   logic [7:0]               r_tx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]    r_rx_wptr;
   logic [DEPTH_LOG2-1:0]    r_rx_rptr;
   logic [DEPTH_LOG2-1:0]    r_tx_wptr;
   logic [DEPTH_LOG2-1:0]    r_tx_rptr;
   logic [LW-1:0]            r_rx_level;
   logic [LW-1:0]            r_tx_level;
   logic [7:0]               r_fifo_data;
   logic                     r_rd_underrun;
   logic                     r_wr_overrun;

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic                     w_rd_fall;
   logic                     w_rd_rise;
   logic                     w_wr_fall;
   rd_state_t                w_rd_state_nxt;
   logic                     w_rd_start;
   logic                     w_rd_underrun_set;
   logic                     w_rx_pop;
   logic                     w_rx_push;
   logic [RXW-1:0]           w_rx_rec_nxt;
   logic                     w_tx_push;
   logic                     w_tx_pop;
   logic                     w_wr_overrun_set;
   logic [TXW-1:0]           w_tx_rec_nxt;
   logic [LW-1:0]            w_rx_level_nxt;
   logic [LW-1:0]            w_tx_level_nxt;

   // A pin that is already low when reset releases must not look like a
   // falling edge, so falls are masked for the first cycle out of reset.
   assign w_rd_fall = r_rd_prev & ~iFIFO_RD_n & ~r_edge_mask;
   assign w_rd_rise = ~r_rd_prev & iFIFO_RD_n;
   assign w_wr_fall = r_wr_prev & ~iFIFO_WR_n & ~r_edge_mask;

   // Pin flags are decoded from registered state only.
   assign oFIFO_RXF_n = (r_rx_level == ZERO_LVL) | (r_rx_rec != RX_REC_ZERO);
   assign oFIFO_TXE_n = (r_tx_level == FULL_LVL) | (r_tx_rec != TX_REC_ZERO);

   assign oHOST_READY = (r_rx_level < FULL_LVL);
   assign oHOST_VALID = (r_tx_level != ZERO_LVL);
   assign oHOST_DATA  = r_tx_mem[r_tx_rptr];

   assign w_rx_push = iHOST_VALID & oHOST_READY;
   assign w_tx_pop  = oHOST_VALID & iHOST_READY;

   assign oFIFO_DATA   = r_fifo_data;
   assign oRX_LEVEL    = r_rx_level;
   assign oTX_LEVEL    = r_tx_level;
   assign oRD_UNDERRUN = r_rd_underrun;
   assign oWR_OVERRUN  = r_wr_overrun;

   // Read FSM next-state, pop request and RXF recovery countdown.
   always_comb begin
      w_rd_state_nxt    = r_rd_state;
      w_rd_start        = 1'b0;
      w_rd_underrun_set = 1'b0;
      w_rx_pop          = 1'b0;
      w_rx_rec_nxt      = r_rx_rec;
      case (r_rd_state)
         R_IDLE: begin
            if (w_rd_fall) begin
               if (!oFIFO_RXF_n) begin
                  w_rd_start     = 1'b1;
                  w_rd_state_nxt = R_ACTIVE;
               end else begin
                  w_rd_underrun_set = 1'b1;
               end
            end else begin
               w_rd_state_nxt = R_IDLE;
            end
         end
         R_ACTIVE: begin
            // The byte is consumed only when the strobe is released.
            if (w_rd_rise) begin
               w_rx_pop       = 1'b1;
               w_rx_rec_nxt   = RX_REC_LOAD;
               w_rd_state_nxt = R_RECOVER;
            end else begin
               w_rd_state_nxt = R_ACTIVE;
            end
         end
         R_RECOVER: begin
            if (w_rd_fall) begin
               w_rd_underrun_set = 1'b1;
            end else begin
               w_rd_underrun_set = 1'b0;
            end
            if (r_rx_rec <= RX_REC_ONE) begin
               w_rx_rec_nxt   = RX_REC_ZERO;
               w_rd_state_nxt = R_IDLE;
            end else begin
               w_rx_rec_nxt   = r_rx_rec - RX_REC_ONE;
            end
         end
         default: begin
            w_rd_state_nxt = R_IDLE;
            w_rx_rec_nxt   = RX_REC_ZERO;
         end
      endcase
   end

   // Write strobe handling: accept, or flag overrun, plus TXE recovery.
   always_comb begin
      w_tx_push        = 1'b0;
      w_wr_overrun_set = 1'b0;
      w_tx_rec_nxt     = r_tx_rec;
      if (w_wr_fall && !oFIFO_TXE_n) begin
         w_tx_push    = 1'b1;
         w_tx_rec_nxt = TX_REC_LOAD;
      end else if (w_wr_fall) begin
         w_wr_overrun_set = 1'b1;
         if (r_tx_rec != TX_REC_ZERO) begin
            w_tx_rec_nxt = r_tx_rec - TX_REC_ONE;
         end else begin
            w_tx_rec_nxt = TX_REC_ZERO;
         end
      end else if (r_tx_rec != TX_REC_ZERO) begin
         w_tx_rec_nxt = r_tx_rec - TX_REC_ONE;
      end else begin
         w_tx_rec_nxt = TX_REC_ZERO;
      end
   end

   // Occupancy update; a simultaneous push and pop leaves the level as is.
   always_comb begin
      w_rx_level_nxt = r_rx_level;
      w_tx_level_nxt = r_tx_level;
      case ({w_rx_push, w_rx_pop})
         2'b10:   w_rx_level_nxt = r_rx_level + ONE_LVL;
         2'b01:   w_rx_level_nxt = r_rx_level - ONE_LVL;
         default: w_rx_level_nxt = r_rx_level;
      endcase
      case ({w_tx_push, w_tx_pop})
         2'b10:   w_tx_level_nxt = r_tx_level + ONE_LVL;
         2'b01:   w_tx_level_nxt = r_tx_level - ONE_LVL;
         default: w_tx_level_nxt = r_tx_level;
      endcase
   end

   // Pin edge history, reset edge mask and read FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_prev   <= 1'b1;
         r_wr_prev   <= 1'b1;
         r_edge_mask <= 1'b1;
         r_rd_state  <= R_IDLE;
      end else begin
         r_rd_prev   <= iFIFO_RD_n;
         r_wr_prev   <= iFIFO_WR_n;
         r_edge_mask <= 1'b0;
         r_rd_state  <= w_rd_state_nxt;
      end
   end

   // Recovery counters, read data latch and sticky violation flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_rec      <= RX_REC_ZERO;
         r_tx_rec      <= TX_REC_ZERO;
         r_fifo_data   <= 8'h00;
         r_rd_underrun <= 1'b0;
         r_wr_overrun  <= 1'b0;
      end else begin
         r_rx_rec <= w_rx_rec_nxt;
         r_tx_rec <= w_tx_rec_nxt;
         if (w_rd_start) begin
            r_fifo_data <= r_rx_mem[r_rx_rptr];
         end
         if (w_rd_underrun_set) begin
            r_rd_underrun <= 1'b1;
         end
         if (w_wr_overrun_set) begin
            r_wr_overrun <= 1'b1;
         end
      end
   end

   // RX buffer pointers and level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_level <= ZERO_LVL;
      end else begin
         if (w_rx_push) begin
            r_rx_wptr <= r_rx_wptr + PTR_ONE;
         end
         if (w_rx_pop) begin
            r_rx_rptr <= r_rx_rptr + PTR_ONE;
         end
         r_rx_level <= w_rx_level_nxt;
      end
   end

   // TX buffer pointers and level.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_level <= ZERO_LVL;
      end else begin
         if (w_tx_push) begin
            r_tx_wptr <= r_tx_wptr + PTR_ONE;
         end
         if (w_tx_pop) begin
            r_tx_rptr <= r_tx_rptr + PTR_ONE;
         end
         r_tx_level <= w_tx_level_nxt;
      end
   end

   // Buffer storage; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (rst && w_rx_push) begin
         r_rx_mem[r_rx_wptr] <= iHOST_DATA;
      end
      if (rst && w_tx_push) begin
         r_tx_mem[r_tx_wptr] <= iFIFO_DATA;
      end
   end

endmodule
